// File: rtl/dmem_responder.sv
// Data-memory responder for the LSU load/store path: one request at a time,
// fixed wait states, then a held response until the initiator takes it.
module dmem_responder #(
    parameter int unsigned MEM_BYTES   = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cap_write;
    logic [1:0]    cap_size;
    logic          cap_unsigned;
    logic [63:0]   cap_addr;
    logic [63:0]   cap_wdata;
    logic [7:0]    mem [MEM_BYTES];

    logic          do_access_c;
    logic          acc_write_c;
    logic [1:0]    acc_size_c;
    logic          acc_unsigned_c;
    logic [63:0]   acc_addr_c;
    logic [63:0]   acc_wdata_c;
    logic [3:0]    acc_nbytes_c;
    logic          acc_err_c;
    logic [AW-1:0] acc_idx_c;
    logic [63:0]   raw_c;
    logic [63:0]   load_c;

    // With zero wait states the access happens on the acceptance edge from live inputs.
    always_comb begin
        do_access_c = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (cnt == LAST_WAIT));
        if (state == S_IDLE) begin
            acc_write_c    = req_write;
            acc_size_c     = req_size;
            acc_unsigned_c = req_unsigned;
            acc_addr_c     = req_addr;
            acc_wdata_c    = req_wdata;
        end else begin
            acc_write_c    = cap_write;
            acc_size_c     = cap_size;
            acc_unsigned_c = cap_unsigned;
            acc_addr_c     = cap_addr;
            acc_wdata_c    = cap_wdata;
        end
        acc_nbytes_c = 4'(1) << acc_size_c;
        acc_idx_c    = acc_addr_c[AW-1:0];
        // Full-width sum so high addresses cannot wrap back into range.
        acc_err_c = ((acc_addr_c[2:0] & 3'(acc_nbytes_c - 4'd1)) != 3'd0) ||
                    (({1'b0, acc_addr_c} + 65'(acc_nbytes_c)) > 65'(MEM_BYTES));
        raw_c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (4'(i) < acc_nbytes_c) begin
                raw_c[8*i +: 8] = mem[AW'(acc_idx_c + AW'(i))];
            end
        end
        case (acc_size_c)
            2'b00:   load_c = acc_unsigned_c ? {56'd0, raw_c[7:0]}  : {{56{raw_c[7]}},  raw_c[7:0]};
            2'b01:   load_c = acc_unsigned_c ? {48'd0, raw_c[15:0]} : {{48{raw_c[15]}}, raw_c[15:0]};
            2'b10:   load_c = acc_unsigned_c ? {32'd0, raw_c[31:0]} : {{32{raw_c[31]}}, raw_c[31:0]};
            default: load_c = raw_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            cap_write    <= 1'b0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            for (int unsigned i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_access_c) begin
                if (!acc_err_c && acc_write_c) begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (4'(i) < acc_nbytes_c) begin
                            mem[AW'(acc_idx_c + AW'(i))] <= acc_wdata_c[8*i +: 8];
                        end
                    end
                end
                rsp_rdata <= (acc_err_c || acc_write_c) ? 64'd0 : load_c;
                rsp_error <= acc_err_c;
                rsp_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_write    <= req_write;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        cnt          <= '0;
                        req_ready    <= 1'b0;
                        state        <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == LAST_WAIT) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance share stimulus
// and are both checked every cycle against a timestamped request-level model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        ready0, ready2, valid0, valid2, err0, err2;
    logic [63:0] rdata0, rdata2;

    always #5 clk = ~clk;

    dmem_responder #(.MEM_BYTES(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid0),
        .rsp_ready(rsp_ready), .rsp_rdata(rdata0), .rsp_error(err0));

    dmem_responder #(.MEM_BYTES(256), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(valid2),
        .rsp_ready(rsp_ready), .rsp_rdata(rdata2), .rsp_error(err2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic rdy(input int i); return (i == 0) ? ready0 : ready2; endfunction
    function automatic logic vld(input int i); return (i == 0) ? valid0 : valid2; endfunction
    function automatic logic [63:0] rdv(input int i); return (i == 0) ? rdata0 : rdata2; endfunction
    function automatic logic erv(input int i); return (i == 0) ? err0 : err2; endfunction

    // Request-level model: each instance has its own memory image and response deadline.
    logic [7:0]      mm [2][256];
    bit              mv [2], mr [2], mp [2], me [2];
    logic [63:0]     md [2];
    longint unsigned due [2];
    longint unsigned cyc = 0;
    bit              pw [2], pu [2];
    logic [1:0]      ps [2];
    logic [63:0]     pa [2], pd [2];
    bit              armed = 1'b0;

    function automatic void model_access(input int i);
        longint unsigned nb = 64'd1 << ps[i];
        longint unsigned a  = pa[i];
        logic [63:0]     v  = '0;
        if ((a % nb) != 0 || a > 256 - nb) begin
            md[i] = '0; me[i] = 1'b1;
        end else if (pw[i]) begin
            for (longint unsigned k = 0; k < nb; k++) mm[i][int'(a + k)] = pd[i][8*k +: 8];
            md[i] = '0; me[i] = 1'b0;
        end else begin
            for (longint unsigned k = 0; k < nb; k++) v = v | (64'(mm[i][int'(a + k)]) << (8 * k));
            if (!pu[i] && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
            md[i] = v; me[i] = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int k = 0; k < 256; k++) mm[i][k] = 8'h00;
                mv[i] = 0; mr[i] = 1; mp[i] = 0; md[i] = '0; me[i] = 0;
            end else begin
                if (mv[i] && rsp_ready) begin
                    mv[i] = 0; mr[i] = 1;
                end else if (mr[i] && req_valid) begin
                    mr[i] = 0; mp[i] = 1; due[i] = cyc + ((i == 0) ? 0 : 2);
                    pw[i] = req_write; ps[i] = req_size; pu[i] = req_unsigned;
                    pa[i] = req_addr; pd[i] = req_wdata;
                end
                if (mp[i] && cyc == due[i]) begin
                    model_access(i); mp[i] = 0; mv[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed && !reset) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cmp%0d req_ready", i), 64'(rdy(i)), 64'(mr[i]));
                chk($sformatf("cmp%0d rsp_valid", i), 64'(vld(i)), 64'(mv[i]));
                chk($sformatf("cmp%0d rsp_rdata", i), rdv(i), md[i]);
                chk($sformatf("cmp%0d rsp_error", i), 64'(erv(i)), 64'(me[i]));
            end
        end
    end

    task automatic drive(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [63:0] a, input logic [63:0] wd);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
    endtask

    // One full transaction observed on instance inst, with literal expectations.
    task automatic xfer(input int inst, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] a, input logic [63:0] wd, input string nm,
                        input logic [63:0] exp_rd, input bit exp_er);
        int n;
        @(negedge clk);
        drive(wr, sz, uns, a, wd);
        rsp_ready = 1'b0;
        n = 0;
        while (!rdy(inst) && n < 20) begin @(negedge clk); n++; end
        chk({nm, " accept"}, 64'(rdy(inst)), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!vld(inst) && n < 20);
        chk({nm, " latency"}, 64'(n), (inst == 0) ? 64'd1 : 64'd3);
        chk({nm, " rdata"}, rdv(inst), exp_rd);
        chk({nm, " error"}, 64'(erv(inst)), 64'(exp_er));
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 64'(ready2), 64'd1);
        chk("reset rsp_valid", 64'(valid2), 64'd0);
        chk("reset rsp_rdata", rdata2, 64'd0);
        chk("reset rsp_error", 64'(err2), 64'd0);

        xfer(1, 1, 2'b11, 0, 64'h10, 64'h1122334455667788, "sd 10", 64'd0, 0);
        xfer(1, 0, 2'b11, 0, 64'h10, 64'd0, "ld 10", 64'h1122334455667788, 0);
        xfer(1, 0, 2'b00, 1, 64'h17, 64'd0, "lbu 17", 64'h11, 0);

        xfer(1, 1, 2'b00, 0, 64'h20, 64'h80, "sb 20", 64'd0, 0);
        xfer(1, 0, 2'b00, 0, 64'h20, 64'd0, "lb 20", 64'hFFFFFFFFFFFFFF80, 0);
        xfer(1, 0, 2'b00, 1, 64'h20, 64'd0, "lbu 20", 64'h80, 0);
        xfer(1, 1, 2'b10, 0, 64'h24, 64'h80000000, "sw 24", 64'd0, 0);
        xfer(1, 0, 2'b10, 0, 64'h24, 64'd0, "lw 24", 64'hFFFFFFFF80000000, 0);
        xfer(1, 0, 2'b10, 1, 64'h24, 64'd0, "lwu 24", 64'h0000000080000000, 0);

        // Backpressure: response held while a second request is offered and ignored.
        @(negedge clk);
        drive(1, 2'b00, 0, 64'h40, 64'h5A);
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!valid2 && n < 20);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, 2'b00, 0, 64'h41, 64'h77);
            chk("bp rsp_valid", 64'(valid2), 64'd1);
            chk("bp req_ready", 64'(ready2), 64'd0);
            chk("bp rsp_rdata", rdata2, 64'd0);
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        xfer(1, 0, 2'b11, 0, 64'h40, 64'd0, "ld 40", 64'h5A, 0);

        xfer(1, 0, 2'b10, 0, 64'h12, 64'd0, "lw 12", 64'd0, 1);
        xfer(1, 1, 2'b10, 0, 64'h22, 64'hDEADBEEF, "sw 22", 64'd0, 1);
        xfer(1, 0, 2'b11, 0, 64'h20, 64'd0, "ld 20", 64'h8000000000000080, 0);
        xfer(1, 0, 2'b11, 0, 64'hFC, 64'd0, "ld FC", 64'd0, 1);
        xfer(1, 0, 2'b00, 0, 64'h100, 64'd0, "lb 100", 64'd0, 1);
        xfer(1, 0, 2'b00, 0, 64'hFF, 64'd0, "lb FF", 64'd0, 0);

        // Reset lands while the store is still waiting.
        @(negedge clk);
        drive(1, 2'b11, 0, 64'h30, 64'hAA);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst rsp_valid", 64'(valid2), 64'd0);
        chk("rst req_ready", 64'(ready2), 64'd1);
        xfer(1, 0, 2'b11, 0, 64'h30, 64'd0, "ld 30", 64'd0, 0);

        // Zero wait states: single-cycle latency, then one request per two cycles.
        xfer(0, 1, 2'b11, 0, 64'h08, 64'hCAFEF00D12345678, "w0 sd 08", 64'd0, 0);
        @(negedge clk);
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        drive(0, 2'b11, 0, 64'h08, 64'd0);
        rsp_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (valid0) n++;
        end
        chk("w0 throughput", 64'(n), 64'd4);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
